fetch_stage: RTL

Instruction-fetch (IF) stage of the five-stage MIPS pipeline, sitting directly upstream of the decode stage. It holds the word-addressed program counter, the instruction memory and its byte-serial debug loader, and the IF/ID pipeline latch. It selects the next PC from the decode stage's control, branch, jump and register targets. It honours the hazard unit's stall signals and freezes on halt.

---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_instr_mem.sv | 29 ++
 rtl/fetch_stage.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared definitions for the MIPS instruction-fetch stage.
// Holds the next-PC source encodings, the NOP word and the default
// instruction-memory address width (`ADDRWIDTH, overridable on the command line).

`ifndef ADDRWIDTH
`define ADDRWIDTH 5
`endif

package fetch_stage_pkg;

  // Next-PC source select driven by the decode stage
  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_REG    = 2'b11
  } pc_src_e;

  // All-zero word is sll $0,$0,0, the canonical MIPS NOP
  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int NB_DATA_DEF = 32;
  localparam int NB_BYTE_DEF = 8;

endpackage

// File: rtl/fetch_stage_instr_mem.sv
// fetch_stage_instr_mem: instruction memory of the fetch stage.
// 2^NB_ADDR words of NB_DATA bits, one synchronous write port used by the
// byte-serial loader and one asynchronous read port addressed by the PC.
// Contents are deliberately not reset so a loaded program survives a reset.

module fetch_stage_instr_mem #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5
) (
  input  logic               i_clock,
  input  logic               wr_en_i,
  input  logic [NB_ADDR-1:0] wr_addr_i,
  input  logic [NB_DATA-1:0] wr_data_i,
  input  logic [NB_ADDR-1:0] rd_addr_i,
  output logic [NB_DATA-1:0] rd_data_o
);

  logic [NB_DATA-1:0] mem_q [0:(1<<NB_ADDR)-1];

  // Loader write port: one full word per write strobe
  always_ff @(posedge i_clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the five-stage MIPS pipeline.
// Owns the word-addressed PC, the instruction memory with its byte-serial
// debug loader, and the IF/ID latch. Honours hazard-unit stalls, the debug
// run enable and a sticky halt.
// Build option: define FETCH_FLUSH_EN to squash the instruction fetched in
// the same cycle as a taken branch/jump (replaced by NOP); leave it undefined
// for single-delay-slot behaviour.

`ifndef ADDRWIDTH
`define ADDRWIDTH 5
`endif

module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = `ADDRWIDTH,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_pc_write,
  input  logic               i_IF_ID_write,
  input  logic               i_branch_or_jump,
  input  logic [1:0]         i_pc_src,
  input  logic [NB_ADDR-1:0] i_addr_branch,
  input  logic [NB_ADDR-1:0] i_addr_jump,
  input  logic [NB_ADDR-1:0] i_addr_register,
  input  logic               i_halt,
  input  logic               i_wr_en,
  input  logic [NB_BYTE-1:0] i_wr_byte,
  output logic [NB_DATA-1:0] o_instruction,
  output logic [NB_ADDR-1:0] o_pc,
  output logic [NB_ADDR-1:0] o_pc_current,
  output logic               o_mem_full,
  output logic               o_halted
);

  localparam int BYTES_PER_WORD = NB_DATA / NB_BYTE;
  localparam int NB_BCNT        = $clog2(BYTES_PER_WORD);
  localparam int NB_BUF         = NB_DATA - NB_BYTE;

  logic [NB_ADDR-1:0] pc_q, pc_d;
  logic [NB_DATA-1:0] instr_q, instr_d;
  logic [NB_ADDR-1:0] ifPc_q, ifPc_d;
  logic               halted_q, halted_d;
  logic [NB_BCNT-1:0] byteCnt_q, byteCnt_d;
  logic [NB_ADDR-1:0] wordPtr_q, wordPtr_d;
  logic [NB_BUF-1:0]  wordBuf_q, wordBuf_d;
  logic               memFull_q, memFull_d;

  logic               loadStrobe;
  logic               lastByte;
  logic               runActive;
  logic               memWrEn;
  logic [NB_DATA-1:0] memWrData;
  logic [NB_DATA-1:0] memRdData;
  logic [NB_DATA-1:0] fetchedInstr;
  logic [NB_ADDR-1:0] pcPlusOne;
  logic [NB_ADDR-1:0] pcTarget;

  // The loader only listens while the pipeline is stopped and not halted
  assign loadStrobe = i_wr_en & ~i_enable & ~halted_q & ~memFull_q & ~i_reset;
  assign lastByte   = (byteCnt_q == NB_BCNT'(BYTES_PER_WORD - 1));
  assign runActive  = i_enable & ~halted_q;
  assign pcPlusOne  = pc_q + NB_ADDR'(1);
  assign memWrEn    = loadStrobe & lastByte;
  assign memWrData  = {wordBuf_q, i_wr_byte};

  fetch_stage_instr_mem #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_instr_mem (
    .i_clock   (i_clock),
    .wr_en_i   (memWrEn),
    .wr_addr_i (wordPtr_q),
    .wr_data_i (memWrData),
    .rd_addr_i (pc_q),
    .rd_data_o (memRdData)
  );

  // Next-PC mux: decode only redirects when it reports a taken branch/jump
  always_comb begin
    pcTarget = pcPlusOne;
    if (i_branch_or_jump) begin
      case (pc_src_e'(i_pc_src))
        PC_SRC_SEQ:    pcTarget = pcPlusOne;
        PC_SRC_BRANCH: pcTarget = i_addr_branch;
        PC_SRC_JUMP:   pcTarget = i_addr_jump;
        PC_SRC_REG:    pcTarget = i_addr_register;
        default:       pcTarget = pcPlusOne;
      endcase
    end
  end

  // Word entering IF/ID, squashed on a redirect when flushing is built in
  always_comb begin
    fetchedInstr = memRdData;
`ifdef FETCH_FLUSH_EN
    if (i_branch_or_jump) begin
      fetchedInstr = NOP;
    end
`endif
  end

  // Next-state for loader counters, PC, IF/ID latch and halt flag
  always_comb begin
    pc_d      = pc_q;
    instr_d   = instr_q;
    ifPc_d    = ifPc_q;
    halted_d  = halted_q;
    byteCnt_d = byteCnt_q;
    wordPtr_d = wordPtr_q;
    wordBuf_d = wordBuf_q;
    memFull_d = memFull_q;

    if (loadStrobe) begin
      if (lastByte) begin
        byteCnt_d = '0;
        wordPtr_d = wordPtr_q + NB_ADDR'(1);
        if (&wordPtr_q) begin
          memFull_d = 1'b1;
        end
      end else begin
        byteCnt_d = byteCnt_q + NB_BCNT'(1);
        wordBuf_d = {wordBuf_q[NB_BUF-NB_BYTE-1:0], i_wr_byte};
      end
    end

    if (runActive) begin
      if (i_pc_write) begin
        pc_d = pcTarget;
      end
      if (i_IF_ID_write) begin
        instr_d = fetchedInstr;
        ifPc_d  = pcPlusOne;
      end
      if (i_halt) begin
        halted_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; memory contents are left alone
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pc_q      <= '0;
      instr_q   <= '0;
      ifPc_q    <= '0;
      halted_q  <= 1'b0;
      byteCnt_q <= '0;
      wordPtr_q <= '0;
      wordBuf_q <= '0;
      memFull_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ifPc_q    <= ifPc_d;
      halted_q  <= halted_d;
      byteCnt_q <= byteCnt_d;
      wordPtr_q <= wordPtr_d;
      wordBuf_q <= wordBuf_d;
      memFull_q <= memFull_d;
    end
  end

  assign o_instruction = instr_q;
  assign o_pc          = ifPc_q;
  assign o_pc_current  = pc_q;
  assign o_mem_full    = memFull_q;
  assign o_halted      = halted_q;

endmodule
